// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one shared full-adder slice, LSB first, WIDTH cycles per
// operation, with a valid/ready result handshake.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             slice_y;
    logic             slice_z;
    logic             last_bit;

    assign slice_y  = op_a[0] ^ op_b[0] ^ carry;
    assign slice_z  = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: defaulting state_nxt first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)        state_nxt = RUN;
            RUN:     if (last_bit)     state_nxt = DONE;
            DONE:    if (result_ready) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        result_valid = (state == DONE);
    end

    // Subtraction is a + ~b + 1: B is stored inverted and the carry is seeded with sub.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    result <= {slice_y, result[WIDTH-1:1]};
                    carry  <= slice_z;
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        cout <= slice_z;
                        ovf  <= carry ^ slice_z;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: driver pushes arithmetic-model results, a
// negedge monitor compares them, checks latency, and checks stability while DONE.
module tb_serial_add_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         result_ready = 1'b0;
    logic         busy;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         result_valid;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .result(result), .cout(cout), .ovf(ovf),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t   e;
        longint ux = x;
        longint uy = y;
        longint sx = x[W-1] ? ux - (64'sd1 << W) : ux;
        longint sy = y[W-1] ? uy - (64'sd1 << W) : uy;
        longint ur = s ? ux - uy : ux + uy;
        longint sr = s ? sx - sy : sx + sy;
        e.res     = W'(ur);
        e.co      = s ? (ux >= uy) : (ur >= (64'sd1 << W));
        e.ov      = (sr < -(64'sd1 << (W - 1))) || (sr >= (64'sd1 << (W - 1)));
        e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: compare on the rising edge of result_valid, then insist on stability.
    initial begin : monitor
        logic  prev_valid = 1'b0;
        exp_t  cur;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
            end else if (result_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(result_valid), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("result", 32'(result), 32'(cur.res));
                    check("cout", 32'(cout), 32'(cur.co));
                    check("ovf", 32'(ovf), 32'(cur.ov));
                    check("latency", 32'(cyc - cur.acc_cyc), 32'(W));
                end
                prev_valid = 1'b1;
            end else if (result_valid) begin
                check("hold_result", 32'({result, cout, ovf}), 32'({cur.res, cur.co, cur.ov}));
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        while (busy && guard < 4 * W) begin
            @(negedge clk);
            guard++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
        a = x; b = y; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = model(x, y, s);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        check("busy_run", 32'(busy), 32'd1);
    endtask

    // Full operation: optional junk on start/a/b/sub while busy; ready after hold cycles.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input int hold, input bit junk);
        int guard = 0;
        issue(x, y, s);
        while (!result_valid && guard < W + 4) begin
            if (junk) begin
                a = W'($urandom); b = W'($urandom); sub = 1'($urandom); start = 1'b1;
            end
            @(negedge clk);
            guard++;
        end
        if (!result_valid) begin
            check("valid_timeout", 32'(result_valid), 32'd1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                a = W'($urandom); b = W'($urandom); sub = 1'($urandom); start = 1'b1;
            end
            @(negedge clk);
            check("busy_done", 32'({busy, result_valid}), 32'b11);
        end
        result_ready = 1'b1;
        start = junk;
        @(negedge clk);
        result_ready = 1'b0;
        start = 1'b0;
        check("after_ready", 32'({busy, result_valid}), 32'b00);
    endtask

    initial begin : global_timeout
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset = 1'b1;
        #12;
        check("reset_outputs", 32'({busy, result_valid, result, cout, ovf}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 0, 1'b0);
        run_op(8'h10, 8'h20, 1'b1, 2, 1'b0);
        run_op(8'hC3, 8'h7E, 1'b0, 5, 1'b1);

        // Abort mid-RUN: outputs clear asynchronously and no result appears.
        issue(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("abort_outputs", 32'({busy, result_valid, result, cout, ovf}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            check("abort_no_valid", 32'({busy, result_valid}), 32'b00);
        end
        run_op(8'h01, 8'h02, 1'b0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin an operation.
REQ-005 The block SHALL have port sub, input, 1 bit, operation select: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each, operands; sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit, high while an operation is in progress or a result is pending.
REQ-008 The block SHALL have port result, output, WIDTH bits, sum or difference.
REQ-009 The block SHALL have port cout, output, 1 bit, final carry out of the MSB; for subtraction 1 = no borrow.
REQ-010 The block SHALL have port ovf, output, 1 bit, signed two's-complement overflow.
REQ-011 The block SHALL have port result_valid, output, 1 bit, result/cout/ovf are valid.
REQ-012 The block SHALL have port result_ready, input, 1 bit, consumer accepts the result.

Function
REQ-013 The block SHALL compute through one shared 1-bit full-adder slice (inputs cin, a, b; outputs y = a^b^cin, z = majority(a,b,cin)), one bit per cycle, LSB first.
REQ-014 The state machine SHALL have states IDLE, RUN, DONE.
REQ-015 In IDLE with start=1 at an edge, the block SHALL latch a into operand register A, latch b into B (b inverted when sub=1), set carry = sub, clear bit counter, go to RUN.
REQ-016 In IDLE with start=0, state and all registers SHALL hold.
REQ-017 Each RUN edge SHALL feed A[0], B[0], carry to the slice, shift y into result MSB-first-in (right shift), store z into carry, shift A and B right, increment counter.
REQ-018 On the RUN edge processing bit WIDTH-1, the block SHALL capture cout = z, ovf = carry-into-MSB XOR z, and go to DONE.
REQ-019 Latency SHALL be exactly WIDTH cycles: result_valid rises WIDTH edges after the start-accept edge.
REQ-020 In DONE, result_valid SHALL be 1 and result, cout, ovf SHALL hold stable until result_ready=1 at an edge, then the state SHALL return to IDLE and result_valid SHALL fall.
REQ-021 start SHALL be ignored in RUN and DONE; a start coincident with the accepting result_ready edge SHALL NOT be accepted (needs one IDLE cycle).
REQ-022 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-023 Changes on a, b, sub after the accept edge SHALL NOT affect the operation in progress.
REQ-024 result_ready SHALL be ignored outside DONE.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never wrap within an operation.

Reset
REQ-026 reset=1 SHALL force, asynchronously, state=IDLE, A, B, result, counter, carry, cout, ovf = 0, result_valid = 0, busy = 0.
REQ-027 reset asserted mid-RUN or in DONE SHALL abort the operation with no result_valid pulse; the first start after reset release SHALL be accepted normally.

Verification (WIDTH=8)
REQ-028 a=0x5A, b=0x3C, sub=0, start pulse -> result_valid after 8 cycles, result=0x96, cout=0, ovf=1.
REQ-029 a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1, ovf=0; a=0x80, b=0x01, sub=1 -> result=0x7F, cout=1, ovf=1.
REQ-030 a=0x10, b=0x20, sub=1 -> result=0xF0, cout=0, ovf=0.
REQ-031 result_ready held 0 for 5 cycles in DONE, start pulsed and a/b changed during RUN and DONE -> result and flags stable, busy=1, no new operation begins; result_ready=1 -> IDLE next edge.
REQ-032 reset pulsed after 4 RUN cycles -> all outputs 0 immediately, no result_valid; next start a=0x01, b=0x02, sub=0 -> result=0x03 after 8 cycles.
